mux_req_arbiter: RTL

//  Round-robin arbiter sharing the 4-channel mux datapath input (in_req/in_chan/in_data) among 4 sources.

---
 rtl/mux_req_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mux_req_arbiter.sv
// Round-robin arbiter in front of the 4-channel mux input.
// Each grant carries up to BURST_MAX beats. in_req is never raised while
// q_full is high. The block also keeps per-channel beat counters and a
// sticky watchdog that flags a grant blocked by q_full for too long.
module mux_req_arbiter #(
  parameter int DATA_W      = 32,
  parameter int BURST_MAX   = 2,
  parameter int STALL_LIMIT = 64,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [3:0]            src_valid,
  input  logic [4*DATA_W-1:0]   src_data,
  output logic [3:0]            src_ready,
  input  logic                  q_full,
  output logic                  in_req,
  output logic [1:0]            in_chan,
  output logic [DATA_W-1:0]     in_data,
  output logic                  owner_vld,
  output logic                  stall_err,
  input  logic [1:0]            cnt_sel,
  input  logic                  cnt_clr,
  output logic [CNT_W-1:0]      cnt_val
);

  localparam int BURST_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam int STALL_W = $clog2(STALL_LIMIT + 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e             state_q;
  logic [1:0]         rr_ptr_q;
  logic [1:0]         owner_q;
  logic [BURST_W-1:0] burst_cnt_q;
  logic [STALL_W-1:0] stall_cnt_q;
  logic [STALL_W-1:0] stall_cnt_d;
  logic               stall_err_q;
  logic [CNT_W-1:0]   cnt_q [4];

  logic               beat;
  logic               stalled;
  logic               burst_end;
  logic               pick_vld;
  logic [1:0]         pick_idx;

  // A beat is a push accepted by the mux this cycle.
  assign beat      = (state_q == GRANT) & en & src_valid[owner_q] & ~q_full;
  assign stalled   = (state_q == GRANT) & en & src_valid[owner_q] & q_full;
  assign burst_end = (burst_cnt_q == BURST_W'(BURST_MAX - 1));

  assign in_req    = beat;
  assign in_chan   = beat ? owner_q : 2'd0;
  assign in_data   = beat ? src_data[owner_q*DATA_W +: DATA_W] : '0;
  assign src_ready = beat ? (4'b0001 << owner_q) : 4'b0000;
  assign owner_vld = (state_q == GRANT);
  assign stall_err = stall_err_q;
  assign cnt_val   = cnt_q[cnt_sel];

  // Round-robin pick: first valid source starting at rr_ptr, wrapping mod 4.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    pick_vld = 1'b0;
    pick_idx = rr_ptr_q;
    // Scan from the far end so the candidate closest to rr_ptr wins.
    for (int k = 3; k >= 0; k--) begin
      if (src_valid[rr_ptr_q + 2'(k)]) begin
        pick_vld = 1'b1;
        pick_idx = rr_ptr_q + 2'(k);
      end
    end
  end

  // Grant FSM: IDLE picks an owner, GRANT streams beats until burst end, drop or disable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 2'd0;
      owner_q     <= 2'd0;
      burst_cnt_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
      unique case (state_q)
        IDLE: begin
          if (en && pick_vld) begin
            owner_q     <= pick_idx;
            burst_cnt_q <= '0;
            state_q     <= GRANT;
          end
        end
        GRANT: begin
          if (beat) begin
            burst_cnt_q <= burst_cnt_q + 1'b1;
            if (burst_end) begin
              state_q  <= IDLE;
              rr_ptr_q <= owner_q + 2'd1;
            end
          end else if (!en) begin
            state_q <= IDLE;
          end else if (!src_valid[owner_q]) begin
            state_q  <= IDLE;
            rr_ptr_q <= owner_q + 2'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Watchdog count: grows only while the owner is blocked by q_full, else clears.
  always_comb begin
    stall_cnt_d = '0;
    if (stalled) begin
      stall_cnt_d = (stall_cnt_q == STALL_W'(STALL_LIMIT)) ? stall_cnt_q
                                                            : stall_cnt_q + 1'b1;
    end
  end

  // Watchdog registers: the error flag is sticky until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      stall_err_q <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      if (stall_cnt_d == STALL_W'(STALL_LIMIT)) begin
        stall_err_q <= 1'b1;
      end
    end
  end

  // Per-channel beat counters; a clear wins over a same-cycle beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the counter array is reset explicitly because its value is architecturally visible.
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else if (cnt_clr) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else if (beat) begin
      cnt_q[owner_q] <= cnt_q[owner_q] + 1'b1;
    end
  end

endmodule
